pio_chaos_key_bank: RTL and testbench

PIO_CHAOS_KEY_BANK -- requirements
Module: pio_chaos_key_bank

---
 rtl/pio_key_pkg.sv | 30 +++
 rtl/pio_key_handshake.sv | 71 +++++++
 rtl/pio_chaos_key_bank.sv | 109 ++++++++++
 tb/tb_pio_chaos_key_bank.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_key_pkg.sv
// Shared definitions for the chaos key bank: register map, CTRL/STATUS bit
// positions, handshake state encoding and the decoded bus request.
package pio_key_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_COUNT  = 4'd10;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_PENDING = 1;
    localparam int STAT_DONE    = 2;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/pio_key_handshake.sv
// Update handshake toward the chaos generator: IDLE/REQ FSM, queued-commit
// flag, sticky DONE and the acknowledged-update counter.
module pio_key_handshake
    import pio_key_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             commit,
    input  logic             update_ack,
    input  logic             done_clr,
    output state_t           state,
    output logic             pending,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             load
);

    state_t           state_nx;
    logic             pending_nx;
    logic             done_nx;
    logic [CNT_W-1:0] count_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            done    <= done_nx;
            count   <= count_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        done_nx    = done;
        count_nx   = count;
        load       = 1'b0;
        // Clear first so a same-cycle completion below overrides it.
        if (done_clr)
            done_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit) begin
                    load     = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (update_ack) begin
                    done_nx  = 1'b1;
                    count_nx = count + 1'b1;
                    if (pending || commit) begin
                        load       = 1'b1;
                        pending_nx = 1'b0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (commit) begin
                    pending_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/pio_chaos_key_bank.sv
// Avalon-MM key bank: shadow registers written by software, active registers
// driven to the chaos generator and swapped in atomically on commit.
module pio_chaos_key_bank
    import pio_key_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     update_valid,
    input  logic                     update_ack,
    output logic                     irq
);

    bus_req_t req;
    assign req.addr  = address;
    assign req.wr    = chipselect & ~write_n;
    assign req.wdata = writedata;

    logic [NUM_CH-1:0][DATA_W-1:0] shadow, shadow_nx, active;
    logic [NUM_CH-1:0]             sh_hit;
    logic                          auto_en, irq_en;
    logic                          ctrl_wr, status_wr, commit, load;
    state_t                        state;
    logic                          pending, done;
    logic [CNT_W-1:0]              count;

    assign ctrl_wr   = req.wr && (req.addr == ADDR_CTRL);
    assign status_wr = req.wr && (req.addr == ADDR_STATUS);

    // shadow_nx folds in this cycle's write so a commit sees the new value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sh_hit[i]    = req.wr && (req.addr == 4'(i));
            shadow_nx[i] = sh_hit[i] ? req.wdata[DATA_W-1:0] : shadow[i];
        end
    end

    assign commit = (ctrl_wr && req.wdata[CTRL_COMMIT]) || ((|sh_hit) && auto_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RESET_VAL;
                active[i] <= RESET_VAL;
            end
        end else begin
            shadow <= shadow_nx;
            if (load)
                active <= shadow_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_en <= 1'b0;
            irq_en  <= 1'b0;
        end else if (ctrl_wr) begin
            auto_en <= req.wdata[CTRL_AUTO];
            irq_en  <= req.wdata[CTRL_IRQ_EN];
        end
    end

    pio_key_handshake u_hs (
        .clk        (clk),
        .reset_n    (reset_n),
        .commit     (commit),
        .update_ack (update_ack),
        .done_clr   (status_wr && req.wdata[STAT_DONE]),
        .state      (state),
        .pending    (pending),
        .done       (done),
        .count      (count),
        .load       (load)
    );

    assign out_port     = active;
    assign update_valid = (state == ST_REQ);
    assign irq          = done & irq_en;

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (req.addr == 4'(i))
                readdata = 32'(shadow[i]);
        case (req.addr)
            ADDR_CTRL: begin
                readdata[CTRL_AUTO]   = auto_en;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
                readdata[STAT_BUSY]    = update_valid;
                readdata[STAT_PENDING] = pending;
                readdata[STAT_DONE]    = done;
            end
            ADDR_COUNT: readdata = 32'(count);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pio_chaos_key_bank.sv
// Self-checking bench for pio_chaos_key_bank: directed scenarios plus random
// traffic compared against a behavioural register/handshake model.
module tb_pio_chaos_key_bank;

    localparam int                NUM_CH = 2;
    localparam int                DATA_W = 32;
    localparam logic [DATA_W-1:0] RV     = 32'hCAFE_0001;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [3:0]               address;
    logic                     chipselect;
    logic                     write_n;
    logic [31:0]              writedata;
    logic [31:0]              readdata;
    logic [NUM_CH*DATA_W-1:0] out_port;
    logic                     update_valid;
    logic                     update_ack;
    logic                     irq;

    always #5 clk = ~clk;

    pio_chaos_key_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RESET_VAL(RV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .out_port     (out_port),
        .update_valid (update_valid),
        .update_ack   (update_ack),
        .irq          (irq)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic [DATA_W-1:0] m_sh  [NUM_CH];
    logic [DATA_W-1:0] m_act [NUM_CH];
    bit                m_busy, m_pend, m_done, m_auto, m_irqen;
    logic [15:0]       m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sh[i]  = RV;
            m_act[i] = RV;
        end
        m_busy = 0; m_pend = 0; m_done = 0; m_auto = 0; m_irqen = 0;
        m_cnt  = 16'h0;
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] exp_out();
        logic [NUM_CH*DATA_W-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i*DATA_W +: DATA_W] = m_act[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (int'(a) < NUM_CH) return 32'(m_sh[a]);
        case (a)
            4'd8:    return {29'h0, m_irqen, m_auto, 1'b0};
            4'd9:    return {29'h0, m_done, m_pend, m_busy};
            4'd10:   return {16'h0, m_cnt};
            default: return 32'h0;
        endcase
    endfunction

    // One clock with the given bus cycle / ack, then advance the model.
    task automatic step(input logic [3:0] a, input bit wr, input logic [31:0] wd, input bit ack);
        bit sh_wr, commit, w1c, completes;
        address = a; chipselect = wr; write_n = !wr; writedata = wd; update_ack = ack;
        @(posedge clk);
        sh_wr  = wr && (int'(a) < NUM_CH);
        commit = (wr && a == 4'd8 && wd[0]) || (sh_wr && m_auto);
        w1c    = wr && a == 4'd9 && wd[2];
        if (sh_wr) m_sh[a] = wd[DATA_W-1:0];
        completes = ack && m_busy;
        if (!m_busy) begin
            if (commit) begin
                m_act  = m_sh;
                m_busy = 1;
            end
        end else if (ack) begin
            m_cnt = m_cnt + 16'd1;
            if (m_pend || commit) begin
                m_act  = m_sh;
                m_pend = 0;
            end else begin
                m_busy = 0;
            end
        end else if (commit) begin
            m_pend = 1;
        end
        if (completes)  m_done = 1;
        else if (w1c)   m_done = 0;
        if (wr && a == 4'd8) begin
            m_auto  = wd[1];
            m_irqen = wd[2];
        end
        #1;
        chipselect = 0; write_n = 1; update_ack = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; chipselect = 1; write_n = 1;
        #1;
        d = readdata;
        chipselect = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; update_ack = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
        step(4'd0, 0, 32'h0, 1);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            vecs++;
            if (d !== exp_rd(4'(a))) begin
                errs++; $display("FAIL reset_read[%0d]: got %h want %h", a, d, exp_rd(4'(a)));
            end
        end
        vecs++;
        if (out_port !== {NUM_CH{RV}}) begin
            errs++; $display("FAIL reset_out_port: got %h want %h", out_port, {NUM_CH{RV}});
        end
        vecs++;
        if (update_valid !== 1'b0 || irq !== 1'b0) begin
            errs++; $display("FAIL reset_flags: got uv=%b irq=%b want 0 0", update_valid, irq);
        end
    endtask

    task automatic test_basic_commit();
        logic [31:0] d;
        step(4'd0, 1, 32'h1234_5678, 0);
        step(4'd8, 1, 32'h1, 0);
        vecs++;
        if (out_port[31:0] !== 32'h1234_5678 || update_valid !== 1'b1) begin
            errs++; $display("FAIL basic_commit: got ch0=%h uv=%b want 12345678 1", out_port[31:0], update_valid);
        end
        step(4'd0, 0, 32'h0, 1);
        rd(4'd9, d);
        vecs++;
        if (update_valid !== 1'b0 || d !== 32'h4) begin
            errs++; $display("FAIL basic_ack: got uv=%b status=%h want 0 4", update_valid, d);
        end
        rd(4'd10, d);
        vecs++;
        if (d !== 32'h1) begin
            errs++; $display("FAIL basic_count: got %h want 1", d);
        end
    endtask

    task automatic test_auto();
        step(4'd8, 1, 32'h2, 0);
        step(4'd1, 1, 32'hA5A5_A5A5, 0);
        vecs++;
        if (out_port[63:32] !== 32'hA5A5_A5A5 || update_valid !== 1'b1) begin
            errs++; $display("FAIL auto_commit: got ch1=%h uv=%b want a5a5a5a5 1", out_port[63:32], update_valid);
        end
        step(4'd0, 0, 32'h0, 1);
        step(4'd8, 1, 32'h0, 0);
    endtask

    task automatic test_pending();
        logic [31:0] d;
        step(4'd8, 1, 32'h1, 0);
        step(4'd0, 1, 32'h1, 0);
        vecs++;
        if (out_port[31:0] !== 32'h1234_5678) begin
            errs++; $display("FAIL pend_shadow_iso: got %h want 12345678", out_port[31:0]);
        end
        step(4'd8, 1, 32'h1, 0);
        rd(4'd9, d);
        vecs++;
        if (d[1] !== 1'b1 || out_port[31:0] !== 32'h1234_5678) begin
            errs++; $display("FAIL pend_set: got status=%h ch0=%h want pending=1 ch0=12345678", d, out_port[31:0]);
        end
        step(4'd0, 0, 32'h0, 1);
        rd(4'd9, d);
        vecs++;
        if (out_port[31:0] !== 32'h1 || update_valid !== 1'b1 || d[1] !== 1'b0) begin
            errs++; $display("FAIL pend_ack1: got ch0=%h uv=%b status=%h want 1 1 pending=0", out_port[31:0], update_valid, d);
        end
        step(4'd0, 0, 32'h0, 1);
        rd(4'd10, d);
        vecs++;
        if (update_valid !== 1'b0 || d !== 32'(m_cnt) || m_cnt !== 16'd4) begin
            errs++; $display("FAIL pend_ack2: got uv=%b count=%h want 0 4", update_valid, d);
        end
    endtask

    task automatic test_irq();
        step(4'd8, 1, 32'h4, 0);
        vecs++;
        if (irq !== 1'b1) begin
            errs++; $display("FAIL irq_set: got %b want 1", irq);
        end
        step(4'd9, 1, 32'h4, 0);
        vecs++;
        if (irq !== 1'b0) begin
            errs++; $display("FAIL irq_clear: got %b want 0", irq);
        end
        step(4'd8, 1, 32'h5, 0);
        step(4'd9, 1, 32'h4, 1);
        vecs++;
        if (irq !== 1'b1 || update_valid !== 1'b0) begin
            errs++; $display("FAIL irq_w1c_vs_ack: got irq=%b uv=%b want 1 0", irq, update_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, wd;
        logic [3:0]  a, ra;
        bit          wr, ack;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 4'($urandom_range(0, NUM_CH - 1));
                2:       a = 4'd8;
                3:       a = 4'd9;
                default: a = 4'($urandom_range(0, 15));
            endcase
            wr  = ($urandom_range(0, 2) != 0);
            ack = ($urandom_range(0, 1) != 0);
            wd  = $urandom;
            step(a, wr, wd, ack);
            vecs++;
            if (out_port !== exp_out() || update_valid !== m_busy || irq !== (m_done & m_irqen)) begin
                errs++;
                $display("FAIL rand_outputs[%0d]: got out=%h uv=%b irq=%b want out=%h uv=%b irq=%b",
                         n, out_port, update_valid, irq, exp_out(), m_busy, m_done & m_irqen);
            end
            ra = 4'($urandom_range(0, 15));
            rd(ra, d);
            vecs++;
            if (d !== exp_rd(ra)) begin
                errs++; $display("FAIL rand_read[%0d] addr %0d: got %h want %h", n, ra, d, exp_rd(ra));
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [31:0] d;
        int          guard;
        guard = 0;
        while (m_busy && guard < 10) begin
            step(4'd0, 0, 32'h0, 1);
            guard++;
        end
        step(4'd8, 1, 32'h0, 0);
        step(4'd8, 1, 32'h1, 0);
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(4'd8, 1, 32'h1, 1);
            guard++;
        end
        rd(4'd10, d);
        vecs++;
        if (d !== 32'h0000_FFFF) begin
            errs++; $display("FAIL count_preload: got %h want 0000ffff", d);
        end
        step(4'd0, 0, 32'h0, 1);
        rd(4'd10, d);
        vecs++;
        if (d !== 32'h0 || update_valid !== 1'b0) begin
            errs++; $display("FAIL count_wrap: got count=%h uv=%b want 0 0", d, update_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        step(4'd0, 1, 32'h0BAD_F00D, 0);
        step(4'd8, 1, 32'h1, 0);
        vecs++;
        if (update_valid !== 1'b1) begin
            errs++; $display("FAIL rst_mid_pre: got uv=%b want 1", update_valid);
        end
        update_ack = 1;
        #2 reset_n = 0;
        #1;
        model_reset();
        vecs++;
        if (update_valid !== 1'b0 || out_port !== exp_out()) begin
            errs++; $display("FAIL rst_mid_async: got uv=%b out=%h want 0 %h", update_valid, out_port, exp_out());
        end
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
        step(4'd0, 0, 32'h0, 1);
        rd(4'd10, d);
        vecs++;
        if (d !== 32'h0 || update_valid !== 1'b0) begin
            errs++; $display("FAIL rst_ack_ignored: got count=%h uv=%b want 0 0", d, update_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_auto();
        test_pending();
        test_irq();
        test_random();
        test_count_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
